i2c_codec_responder: RTL and testbench
======================================

# i2c_codec_responder

I2C target (slave) model of the audio codec's 2-wire control port, the receiving end of the codec initialization sequence. Oversamples SCL/SDA on the system clock, detects START/STOP, shifts in 3-byte write transactions (device address, then two data bytes), drives ACK, and emits one register-write strobe per accepted 16-bit word (7-bit register address + 9-bit data). Used as the bus responder in simulation and as an on-FPGA loopback checker for the initialization path.

## Interface
- DEV_ADDR, 7'h1A, 7-bit device address answered (write byte 0x34)
- i_clk  in  1  system clock, must be at least 8x SCL frequency
- i_rst_n  in  1  synchronous active-low reset, sampled on rising i_clk
- i_sclk  in  1  bus SCL (asynchronous)
- i_sdat  in  1  bus SDA as read from the pad (asynchronous)
- o_sdat_oen  out  1  1 = pull SDA low (ACK); 0 = release
- o_wr_valid  out  1  one-cycle strobe, a word was accepted
- o_wr_addr  out  7  register address of the accepted word, held until next strobe
- o_wr_data  out  9  register data of the accepted word, held until next strobe
- o_busy  out  1  1 from START detection until STOP detection
- o_err  out  1  one-cycle strobe on protocol error

## Operation
- Input path: two-flop synchronizer per line, then one history register; scl_s/sda_s are synchronized values, scl_p/sda_p the previous-cycle values.
- Events (evaluated each cycle): SCL rise = !scl_p & scl_s; SCL fall = scl_p & !scl_s; START = scl_s & scl_p & sda_p & !sda_s; STOP = scl_s & scl_p & !sda_p & sda_s. START/STOP take priority over all state actions.
- Bits are sampled on SCL rise, MSB first, into an 8-bit shift register; a 3-bit bit counter counts 0..7.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP.
  - IDLE: START -> ADDR, bit counter cleared, o_busy=1.
  - ADDR/BYTE1/BYTE2: shift on SCL rise; on the SCL fall after the 8th rise, go to the matching ACK state.
  - ACK_A entry: if byte[7:1]==DEV_ADDR and byte[0]==0, o_sdat_oen=1; if address matches and byte[0]==1 (read), no ACK, o_err pulse, go to WAIT_STOP; address mismatch: no ACK, no error, go to WAIT_STOP.
  - ACK states: o_sdat_oen held 1 until the next SCL fall, then released and state advances (ACK_A->BYTE1, ACK_1->BYTE2, ACK_2->WAIT_STOP).
  - BYTE1 latched into 8-bit holding register at ACK_1 entry.
  - ACK_2 entry: o_wr_addr=hold[7:1], o_wr_data={hold[0], byte2}, o_wr_valid=1 for exactly that cycle.
  - WAIT_STOP: ignore further bits, never ACK.
- START in any non-IDLE state (repeated START): -> ADDR, counter cleared, o_sdat_oen=0 same cycle; o_err pulses if state is BYTE1/ACK_1/BYTE2 (incomplete word).
- STOP in any state -> IDLE, o_busy=0, o_sdat_oen=0; o_err pulses if state is BYTE1, ACK_1 or BYTE2. STOP in WAIT_STOP/ADDR/ACK_A is clean.
- No write is emitted for partial words; accepted words are never retracted.

## Timing
- Reset (i_rst_n=0 at a rising edge): state IDLE, o_sdat_oen=0, o_wr_valid=0, o_busy=0, o_err=0, o_wr_addr=0, o_wr_data=0, synchronizer/history registers = 1 (idle bus). Reset mid-ACK releases SDA on the following edge.
- Bus-to-event latency: 3 i_clk cycles from pad change to event cycle.
- State actions on events are registered: outputs change on the edge after the event cycle (o_sdat_oen asserts 1 cycle after the 8th SCL-fall event; o_wr_valid high 1 cycle after the ACK_2 entry event).
- SDA changes while SCL high outside START/STOP are not possible in legal traffic; they are interpreted as START/STOP as defined above.
- SCL high/low phases shorter than 4 i_clk cycles are unsupported.

## Test plan
- Write 0x34, 0x00, 0x97 -> three ACK low phases, one o_wr_valid with o_wr_addr=7'h00, o_wr_data=9'h097, o_err never high.
- Ten back-to-back writes of the codec init set (last 0x34,0x12,0x01) -> ten strobes in order, last addr 7'h09 data 9'h001, o_busy low after each STOP.
- Write 0x36 then two bytes -> o_sdat_oen stays 0, no o_wr_valid, no o_err.
- Read request 0x35 -> no ACK, one o_err pulse, no o_wr_valid; STOP returns IDLE.
- 0x34, 0x0E, then STOP -> o_err pulse, no o_wr_valid; following full write 0x34,0x0E,0x42 -> addr 7'h07 data 9'h042.
- Assert i_rst_n=0 during ACK_1 low phase -> o_sdat_oen 0 next edge, all outputs at reset values; next full transaction accepted normally.

Source files
------------

// File: rtl/i2c_codec_responder_if.sv
// I2C codec control-port bus bundle: SCL/SDA pad side plus
// the decoded register-write and status outputs.
interface i2c_codec_responder_if;
  logic       i_sclk;
  logic       i_sdat;
  logic       o_sdat_oen;
  logic       o_wr_valid;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data;
  logic       o_busy;
  logic       o_err;

  modport slave (
    input  i_sclk,
    input  i_sdat,
    output o_sdat_oen,
    output o_wr_valid,
    output o_wr_addr,
    output o_wr_data,
    output o_busy,
    output o_err
  );

  modport master (
    output i_sclk,
    output i_sdat,
    input  o_sdat_oen,
    input  o_wr_valid,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_busy,
    input  o_err
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// I2C write-only target for the codec control port: accepts
// 3-byte writes and emits one 7-bit addr / 9-bit data strobe each.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  i2c_codec_responder_if.slave         bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_BYTE1,
    S_ACK_1,
    S_BYTE2,
    S_ACK_2,
    S_WAIT_STOP
  } state_t;

  state_t     r_state, w_state;
  logic       r_scl_m, r_scl_s, r_scl_p;
  logic       r_sda_m, r_sda_s, r_sda_p;
  logic [7:0] r_sh, w_sh;
  logic [7:0] r_hold, w_hold;
  logic [2:0] r_cnt, w_cnt;
  logic       r_full, w_full;
  logic       r_oen, w_oen;
  logic       r_valid, w_valid;
  logic [6:0] r_addr, w_addr;
  logic [8:0] r_data, w_data;
  logic       r_busy, w_busy;
  logic       r_err, w_err;

  logic w_rise, w_fall, w_start, w_stop, w_mid_word;

  assign w_rise  = !r_scl_p & r_scl_s;
  assign w_fall  = r_scl_p & !r_scl_s;
  assign w_start = r_scl_s & r_scl_p & r_sda_p & !r_sda_s;
  assign w_stop  = r_scl_s & r_scl_p & !r_sda_p & r_sda_s;

  // A word is only partially received in these states.
  assign w_mid_word = (r_state == S_BYTE1) || (r_state == S_ACK_1)
                   || (r_state == S_BYTE2);

  always_comb begin
    w_state = r_state;
    w_sh    = r_sh;
    w_hold  = r_hold;
    w_cnt   = r_cnt;
    w_full  = r_full;
    w_oen   = r_oen;
    w_valid = 1'b0;
    w_addr  = r_addr;
    w_data  = r_data;
    w_busy  = r_busy;
    w_err   = 1'b0;
    if (w_stop) begin
      w_state = S_IDLE;
      w_busy  = 1'b0;
      w_oen   = 1'b0;
      w_full  = 1'b0;
      w_err   = w_mid_word;
    end else if (w_start) begin
      w_state = S_ADDR;
      w_cnt   = 3'd0;
      w_full  = 1'b0;
      w_busy  = 1'b1;
      w_oen   = 1'b0;
      w_err   = w_mid_word;
    end else begin
      unique case (r_state)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (w_rise) begin
            w_sh  = {r_sh[6:0], r_sda_s};
            w_cnt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) w_full = 1'b1;
          end else if (w_fall && r_full) begin
            w_full = 1'b0;
            if (r_state == S_ADDR) begin
              if (r_sh[7:1] == DEV_ADDR && !r_sh[0]) begin
                w_state = S_ACK_A;
                w_oen   = 1'b1;
              end else begin
                w_state = S_WAIT_STOP;
                w_err   = (r_sh[7:1] == DEV_ADDR);
              end
            end else if (r_state == S_BYTE1) begin
              w_state = S_ACK_1;
              w_oen   = 1'b1;
              w_hold  = r_sh;
            end else begin
              w_state = S_ACK_2;
              w_oen   = 1'b1;
              w_valid = 1'b1;
              w_addr  = r_hold[7:1];
              w_data  = {r_hold[0], r_sh};
            end
          end
        end
        S_ACK_A, S_ACK_1, S_ACK_2: begin
          if (w_fall) begin
            w_oen = 1'b0;
            w_cnt = 3'd0;
            if (r_state == S_ACK_A)      w_state = S_BYTE1;
            else if (r_state == S_ACK_1) w_state = S_BYTE2;
            else                         w_state = S_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scl_m <= 1'b1;
      r_scl_s <= 1'b1;
      r_scl_p <= 1'b1;
      r_sda_m <= 1'b1;
      r_sda_s <= 1'b1;
      r_sda_p <= 1'b1;
      r_state <= S_IDLE;
      r_sh    <= 8'd0;
      r_hold  <= 8'd0;
      r_cnt   <= 3'd0;
      r_full  <= 1'b0;
      r_oen   <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= 7'd0;
      r_data  <= 9'd0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_scl_m <= bus.i_sclk;
      r_scl_s <= r_scl_m;
      r_scl_p <= r_scl_s;
      r_sda_m <= bus.i_sdat;
      r_sda_s <= r_sda_m;
      r_sda_p <= r_sda_s;
      r_state <= w_state;
      r_sh    <= w_sh;
      r_hold  <= w_hold;
      r_cnt   <= w_cnt;
      r_full  <= w_full;
      r_oen   <= w_oen;
      r_valid <= w_valid;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_busy  <= w_busy;
      r_err   <= w_err;
    end
  end

  assign bus.o_sdat_oen = r_oen;
  assign bus.o_wr_valid = r_valid;
  assign bus.o_wr_addr  = r_addr;
  assign bus.o_wr_data  = r_data;
  assign bus.o_busy     = r_busy;
  assign bus.o_err      = r_err;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bus master tasks drive writes,
// a scoreboard queue holds expected words popped on each strobe.
module tb_i2c_codec_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   err_cnt = 0;
  int   err_exp = 0;
  logic [15:0] sb_q[$];

  i2c_codec_responder_if bus();

  assign bus.i_sclk = m_scl;
  assign bus.i_sdat = m_sda & ~bus.o_sdat_oen;

  i2c_codec_responder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam int Q = 5;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one pop per write strobe.
  always @(negedge clk) begin
    if (rst_n && bus.o_wr_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL wr_unexpected: got %0h expected none",
                 {bus.o_wr_addr, bus.o_wr_data});
      end else begin
        chk("wr_word", {16'd0, bus.o_wr_addr, bus.o_wr_data},
            {16'd0, sb_q.pop_front()});
      end
    end
    if (rst_n && bus.o_err) err_cnt++;
  end

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; wt(Q);
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b1; wt(2 * Q);
  endtask

  task automatic i2c_bit(input logic b);
    m_sda = b; wt(Q);
    m_scl = 1'b1; wt(2 * Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(Q);
    ack = ~bus.i_sdat;
    wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic write_word(input logic [15:0] w, input string nm);
    logic a;
    sb_q.push_back(w);
    i2c_start();
    chk({nm, "_busy"}, {31'd0, bus.o_busy}, 32'd1);
    i2c_byte(8'h34, a); chk({nm, "_ackA"}, {31'd0, a}, 32'd1);
    i2c_byte(w[15:8], a); chk({nm, "_ack1"}, {31'd0, a}, 32'd1);
    i2c_byte(w[7:0], a); chk({nm, "_ack2"}, {31'd0, a}, 32'd1);
    i2c_stop();
    chk({nm, "_idle"}, {31'd0, bus.o_busy}, 32'd0);
  endtask

  logic [15:0] init_set[10] = '{
    16'h1E00, 16'h0C00, 16'h0E42, 16'h1000, 16'h0017,
    16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h1201
  };

  initial begin
    logic a;
    rst_n = 1'b0;
    wt(4);
    @(negedge clk);
    chk("rst_oen", {31'd0, bus.o_sdat_oen}, 32'd0);
    chk("rst_outs", {16'd0, bus.o_wr_valid, bus.o_busy, bus.o_err,
        bus.o_wr_addr, bus.o_wr_data[5:0]}, 32'd0);
    rst_n = 1'b1;
    wt(4);

    write_word(16'h0097, "basic");
    chk("basic_addr", {25'd0, bus.o_wr_addr}, 32'h00);
    chk("basic_data", {23'd0, bus.o_wr_data}, 32'h097);
    chk("basic_err", err_cnt, err_exp);

    foreach (init_set[i]) write_word(init_set[i], "init");
    chk("init_addr", {25'd0, bus.o_wr_addr}, 32'h09);
    chk("init_data", {23'd0, bus.o_wr_data}, 32'h001);
    chk("init_err", err_cnt, err_exp);

    // Foreign device address: never acked, no error.
    i2c_start();
    i2c_byte(8'h36, a); chk("foreign_ackA", {31'd0, a}, 32'd0);
    i2c_byte(8'h00, a); chk("foreign_ack1", {31'd0, a}, 32'd0);
    i2c_byte(8'h97, a); chk("foreign_ack2", {31'd0, a}, 32'd0);
    i2c_stop();
    chk("foreign_err", err_cnt, err_exp);
    chk("foreign_idle", {31'd0, bus.o_busy}, 32'd0);

    // Read request: no ack, one error pulse.
    i2c_start();
    i2c_byte(8'h35, a); chk("read_ack", {31'd0, a}, 32'd0);
    err_exp++;
    i2c_stop();
    chk("read_err", err_cnt, err_exp);
    chk("read_idle", {31'd0, bus.o_busy}, 32'd0);

    // Partial word aborted by STOP.
    i2c_start();
    i2c_byte(8'h34, a); chk("part_ackA", {31'd0, a}, 32'd1);
    i2c_byte(8'h0E, a); chk("part_ack1", {31'd0, a}, 32'd1);
    err_exp++;
    i2c_stop();
    chk("part_err", err_cnt, err_exp);
    write_word(16'h0E42, "after_part");
    chk("after_part_addr", {25'd0, bus.o_wr_addr}, 32'h07);
    chk("after_part_data", {23'd0, bus.o_wr_data}, 32'h042);

    // Reset during the ACK_1 low phase.
    i2c_start();
    i2c_byte(8'h34, a);
    for (int i = 7; i >= 0; i--) i2c_bit(1'b0);
    m_sda = 1'b1; wt(Q);
    @(negedge clk);
    chk("mid_ack_oen", {31'd0, bus.o_sdat_oen}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ack_oen", {31'd0, bus.o_sdat_oen}, 32'd0);
    chk("rst_ack_outs", {bus.o_wr_valid, bus.o_busy, bus.o_err,
        13'd0, bus.o_wr_addr, bus.o_wr_data}, 32'd0);
    m_scl = 1'b1;
    wt(4);
    rst_n = 1'b1;
    wt(4);
    write_word(16'h1000, "post_rst");
    chk("post_rst_addr", {25'd0, bus.o_wr_addr}, 32'h08);
    chk("post_rst_data", {23'd0, bus.o_wr_data}, 32'h000);
    chk("final_err", err_cnt, err_exp);

    wt(10);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
